// File: rtl/fp_cross_pkg.sv
// Shared types and constants for the sequenced FP16 cross-product engine:
// FSM states, product indices, multiply operand table and FP16 packing helper.
package fp_cross_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_MWAIT,
    S_SUB,
    S_SWAIT,
    S_DONE
  } fsm_state_e;

  localparam logic [2:0] P0 = 3'd0;
  localparam logic [2:0] P1 = 3'd1;
  localparam logic [2:0] P2 = 3'd2;
  localparam logic [2:0] P3 = 3'd3;
  localparam logic [2:0] P4 = 3'd4;
  localparam logic [2:0] P5 = 3'd5;

  localparam int unsigned FP_SIGN_BIT = 15;
  localparam logic [15:0] FP_ZERO     = 16'h0000;

  // Component selects: 0 = x, 1 = y, 2 = z
  typedef struct packed {
    logic [1:0] a_sel;
    logic [1:0] b_sel;
  } mul_pair_t;

  function automatic mul_pair_t mul_pair(input logic [2:0] idx);
    case (idx)
      P0:      mul_pair = '{a_sel: 2'd1, b_sel: 2'd2};
      P1:      mul_pair = '{a_sel: 2'd2, b_sel: 2'd1};
      P2:      mul_pair = '{a_sel: 2'd2, b_sel: 2'd0};
      P3:      mul_pair = '{a_sel: 2'd0, b_sel: 2'd2};
      P4:      mul_pair = '{a_sel: 2'd0, b_sel: 2'd1};
      P5:      mul_pair = '{a_sel: 2'd1, b_sel: 2'd0};
      default: mul_pair = '{a_sel: 2'd0, b_sel: 2'd0};
    endcase
  endfunction

  // Round an exact magnitude m to FP16 (nearest-even); biased exponent is
  // (leading-one position + off). Underflow flushes to zero, overflow to inf.
  function automatic logic [15:0] fp16_pack(input logic s, input logic [40:0] m,
                                            input int signed off);
    logic [5:0]  p;
    logic [5:0]  sh;
    logic [9:0]  r;
    logic [40:0] rem;
    logic [40:0] half;
    logic        up;
    logic [14:0] res;
    int signed   e;
    p = '0;
    for (int unsigned i = 0; i < 41; i++) if (m[i]) p = 6'(i);
    if (m == '0 || p < 6'd10) return {s, 15'h0000};
    sh   = p - 6'd10;
    r    = 10'(m >> sh);
    rem  = m & ((41'd1 << sh) - 41'd1);
    half = (sh == '0) ? '0 : (41'd1 << (sh - 6'd1));
    up   = (sh != '0) && ((rem > half) || ((rem == half) && r[0]));
    e    = int'(p) + off;
    if (e >= 31) return {s, 5'h1f, 10'h000};
    if (e <= 0) return {s, 15'h0000};
    // mantissa carry ripples into the exponent (and into inf at the top)
    res = {e[4:0], r} + 15'(up);
    return {s, res};
  endfunction

endpackage

// File: rtl/fp_add_micro.sv
// FP16 adder, LAT registered stages; exact integer alignment then one rounding.
module fp_add_micro
  import fp_cross_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);

  logic [40:0]          ia, ib, m;
  logic                 s;
  logic [15:0]          y_c;
  logic [LAT-1:0][15:0] pipe_q;

  always_comb begin
    ia = (a_i[14:10] == '0) ? '0 : ({30'd0, 1'b1, a_i[9:0]} << (a_i[14:10] - 5'd1));
    ib = (b_i[14:10] == '0) ? '0 : ({30'd0, 1'b1, b_i[9:0]} << (b_i[14:10] - 5'd1));
    if (a_i[15] == b_i[15]) begin
      m = ia + ib;
      s = a_i[15];
    end else if (ia >= ib) begin
      m = ia - ib;
      s = a_i[15];
    end else begin
      m = ib - ia;
      s = b_i[15];
    end
    // exact cancellation yields +0 unless both operands are -0
    if (m == '0) y_c = {a_i[15] & b_i[15], 15'h0000};
    else         y_c = fp16_pack(s, m, -9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= y_c;
      for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign y_o = pipe_q[LAT-1];

endmodule

// File: rtl/fp_cross_seq_opsel.sv
// Multiplier operand mux: picks the a/b components for product index idx_i.
module fp_cross_seq_opsel
  import fp_cross_pkg::*;
(
  input  logic             issue_i,
  input  logic [2:0]       idx_i,
  input  logic [2:0][15:0] a_i,
  input  logic [2:0][15:0] b_i,
  output logic [15:0]      op_a_o,
  output logic [15:0]      op_b_o
);

  mul_pair_t pair;

  always_comb begin
    pair   = mul_pair(idx_i);
    op_a_o = FP_ZERO;
    op_b_o = FP_ZERO;
    if (issue_i) begin
      op_a_o = a_i[pair.a_sel];
      op_b_o = b_i[pair.b_sel];
    end
  end

endmodule

// File: rtl/fp_mul_micro.sv
// FP16 multiplier, LAT registered stages; zero/denormal inputs give signed zero.
module fp_mul_micro
  import fp_cross_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);

  logic [21:0]             prod;
  logic [15:0]             y_c;
  logic [LAT-1:0][15:0]    pipe_q;

  always_comb begin
    prod = 22'({1'b1, a_i[9:0]}) * 22'({1'b1, b_i[9:0]});
    if (a_i[14:10] == '0 || b_i[14:10] == '0)
      y_c = {a_i[15] ^ b_i[15], 15'h0000};
    else
      y_c = fp16_pack(a_i[15] ^ b_i[15], {19'd0, prod},
                      int'(a_i[14:10]) + int'(b_i[14:10]) - 35);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= y_c;
      for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign y_o = pipe_q[LAT-1];

endmodule

// File: rtl/fp_cross_seq.sv
// Time-multiplexed FP16 cross product (one multiplier, one adder, FSM sequenced).
// Define FP_CROSS_VEC2_EN to add the mode_2d port (z-component only, p4/p5).
module fp_cross_seq
  import fp_cross_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_x,
  input  logic [15:0] a_y,
  input  logic [15:0] a_z,
  input  logic [15:0] b_x,
  input  logic [15:0] b_y,
  input  logic [15:0] b_z,
`ifdef FP_CROSS_VEC2_EN
  input  logic        mode_2d,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c_x,
  output logic [15:0] c_y,
  output logic [15:0] c_z
);

  fsm_state_e       state_q;
  logic [2:0]       mul_idx_q;
  logic [1:0]       sub_idx_q;
  logic [2:0][15:0] a_q, b_q;
  logic [5:0][15:0] p_q;
  logic [2:0][15:0] c_q;
  logic             in_ready_q, out_valid_q, last_sum_q;

  logic [MUL_LAT-1:0]      mtv_q;
  logic [MUL_LAT-1:0][2:0] mtag_q;
  logic [ADD_LAT-1:0]      atv_q;
  logic [ADD_LAT-1:0][2:0] atag_q;

  logic        mode_in;
  logic        mul_issue, add_issue;
  logic [15:0] mul_a, mul_b, mul_y;
  logic [15:0] add_a, add_b, add_y, sub_rhs;
  logic        mul_cap, add_cap;
  logic [2:0]  mul_cap_idx, add_cap_idx;

`ifdef FP_CROSS_VEC2_EN
  assign mode_in = mode_2d;
`else
  assign mode_in = 1'b0;
`endif

  assign mul_issue   = (state_q == S_MUL);
  assign add_issue   = (state_q == S_SUB);
  assign mul_cap     = mtv_q[MUL_LAT-1];
  assign mul_cap_idx = mtag_q[MUL_LAT-1];
  assign add_cap     = atv_q[ADD_LAT-1];
  assign add_cap_idx = atag_q[ADD_LAT-1];

  fp_cross_seq_opsel u_opsel (
    .issue_i (mul_issue),
    .idx_i   (mul_idx_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .op_a_o  (mul_a),
    .op_b_o  (mul_b)
  );

  always_comb begin
    sub_rhs = p_q[{sub_idx_q, 1'b1}];
    add_a   = add_issue ? p_q[{sub_idx_q, 1'b0}] : FP_ZERO;
    add_b   = add_issue ? {~sub_rhs[FP_SIGN_BIT], sub_rhs[FP_SIGN_BIT-1:0]} : FP_ZERO;
  end

  fp_mul_micro #(.LAT(MUL_LAT)) u_mul (
    .clk(clk), .rst_n(rst), .a_i(mul_a), .b_i(mul_b), .y_o(mul_y)
  );

  fp_add_micro #(.LAT(ADD_LAT)) u_add (
    .clk(clk), .rst_n(rst), .a_i(add_a), .b_i(add_b), .y_o(add_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtv_q  <= '0;
      mtag_q <= '0;
      atv_q  <= '0;
      atag_q <= '0;
    end else begin
      mtv_q[0]  <= mul_issue;
      mtag_q[0] <= mul_idx_q;
      atv_q[0]  <= add_issue;
      atag_q[0] <= {1'b0, sub_idx_q};
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        mtv_q[i]  <= mtv_q[i-1];
        mtag_q[i] <= mtag_q[i-1];
      end
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
        atv_q[i]  <= atv_q[i-1];
        atag_q[i] <= atag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mul_idx_q   <= P0;
      sub_idx_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      c_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      last_sum_q  <= 1'b0;
    end else begin
      if (mul_cap) p_q[mul_cap_idx] <= mul_y;
      if (add_cap) begin
        c_q[add_cap_idx[1:0]] <= add_y;
        if (add_cap_idx == 3'd2) last_sum_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q        <= {a_z, a_y, a_x};
          b_q        <= {b_z, b_y, b_x};
          c_q        <= '0;
          // 2D mode is captured purely as the starting product/sum index
          mul_idx_q  <= mode_in ? P4 : P0;
          sub_idx_q  <= mode_in ? 2'd2 : 2'd0;
          in_ready_q <= 1'b0;
          state_q    <= S_MUL;
        end
        S_MUL: begin
          if (mul_idx_q == P5) state_q <= S_MWAIT;
          else                 mul_idx_q <= mul_idx_q + 3'd1;
        end
        S_MWAIT: if (mul_cap && mul_cap_idx == P5) state_q <= S_SUB;
        S_SUB: begin
          if (sub_idx_q == 2'd2) state_q <= S_SWAIT;
          else                   sub_idx_q <= sub_idx_q + 2'd1;
        end
        S_SWAIT: if (last_sum_q) begin
          last_sum_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c_x       = c_q[0];
  assign c_y       = c_q[1];
  assign c_z       = c_q[2];

endmodule

// File: tb/tb_fp_cross_seq.sv
// Randomized bench for fp_cross_seq against a real-arithmetic FP16 model;
// exercises default latencies and MUL_LAT=3/ADD_LAT=2 (FP_CROSS_VEC2_EN adds 2D cases).
module tb_fp_cross_seq;

  logic clk = 1'b0;
  logic rst, iv, ordy;
  int   sel;
  logic [2:0][15:0] opa, opb;
`ifdef FP_CROSS_VEC2_EN
  logic md;
`endif

  logic iv0, iv1, or0, or1, ir0, ir1, ov0, ov1;
  logic [15:0] cx0, cy0, cz0, cx1, cy1, cz1;
  logic ir, ov;
  logic [2:0][15:0] cobs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign iv0 = iv && (sel == 0);
  assign iv1 = iv && (sel == 1);
  assign or0 = ordy && (sel == 0);
  assign or1 = ordy && (sel == 1);

  always_comb begin
    ir   = (sel == 1) ? ir1 : ir0;
    ov   = (sel == 1) ? ov1 : ov0;
    cobs = (sel == 1) ? {cz1, cy1, cx1} : {cz0, cy0, cx0};
  end

  fp_cross_seq dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .a_x(opa[0]), .a_y(opa[1]), .a_z(opa[2]),
    .b_x(opb[0]), .b_y(opb[1]), .b_z(opb[2]),
`ifdef FP_CROSS_VEC2_EN
    .mode_2d(md),
`endif
    .out_valid(ov0), .out_ready(or0), .c_x(cx0), .c_y(cy0), .c_z(cz0)
  );

  fp_cross_seq #(.MUL_LAT(3), .ADD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a_x(opa[0]), .a_y(opa[1]), .a_z(opa[2]),
    .b_x(opb[0]), .b_y(opb[1]), .b_z(opb[2]),
`ifdef FP_CROSS_VEC2_EN
    .mode_2d(md),
`endif
    .out_valid(ov1), .out_ready(or1), .c_x(cx1), .c_y(cy1), .c_z(cz1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model: FP16 values via real arithmetic, RNE rounding ----
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) return 0.0;
    v = (1.0 + $itor(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    real ax, m, fl;
    int  e, mant;
    logic s;
    if (x == 0.0) return 16'h0000;
    s  = (x < 0.0);
    ax = s ? -x : x;
    e  = 0;
    while (ax >= pow2(e + 1)) e++;
    while (ax < pow2(e)) e--;
    m  = ax / pow2(e) * 1024.0;
    fl = $floor(m);
    if ((m - fl > 0.5) || ((m - fl == 0.5) && ($rtoi(fl) % 2 == 1))) fl = fl + 1.0;
    if (fl >= 2048.0) begin fl = 1024.0; e++; end
    if (e + 15 >= 31) return {s, 5'h1f, 10'h000};
    if (e + 15 <= 0) return {s, 15'h0000};
    mant = $rtoi(fl) - 1024;
    return {s, 5'(e + 15), 10'(mant)};
  endfunction

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) * h2r(b));
  endfunction

  function automatic logic [15:0] fsub(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) - h2r(b));
  endfunction

  function automatic logic [2:0][15:0] cross_ref(input logic [2:0][15:0] a,
                                                 input logic [2:0][15:0] b,
                                                 input logic m2d);
    logic [2:0][15:0] c;
    c[0] = fsub(fmul(a[1], b[2]), fmul(a[2], b[1]));
    c[1] = fsub(fmul(a[2], b[0]), fmul(a[0], b[2]));
    c[2] = fsub(fmul(a[0], b[1]), fmul(a[1], b[0]));
    if (m2d) begin c[0] = 16'h0000; c[1] = 16'h0000; end
    return c;
  endfunction

  // normal operands with exponents 2..5 keep products and sums in normal range
  function automatic logic [15:0] rand_h();
    logic [15:0] h;
    h[15]    = 1'($urandom_range(0, 1));
    h[14:10] = 5'(17 + $urandom_range(0, 3));
    h[9:0]   = 10'($urandom);
    return h;
  endfunction

  function automatic logic [2:0][15:0] rand_v();
    return {rand_h(), rand_h(), rand_h()};
  endfunction

  task automatic do_op(input string tag, input logic [2:0][15:0] a, input logic [2:0][15:0] b,
                       input logic m2d, input int hold, input bit disturb, input int exp_lat,
                       output logic [2:0][15:0] c);
    logic [2:0][15:0] exp_c;
    bit stable;
    int lat;
    exp_c = cross_ref(a, b, m2d);
    c = '0;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(ir), 32'd1);
    opa = a; opb = b; iv = 1'b1;
`ifdef FP_CROSS_VEC2_EN
    md = m2d;
`endif
    if (disturb) ordy = 1'b1;
    @(negedge clk);
    iv  = 1'b0;
    lat = 0;
    if (disturb) begin
      for (int i = 0; i < 3; i++) begin
        opa = rand_v(); opb = rand_v(); iv = (i != 1);
`ifdef FP_CROSS_VEC2_EN
        md = ~m2d;
`endif
        @(negedge clk);
        lat++;
      end
      iv = 1'b0;
    end
    while (!ov && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!ov) begin
      check({tag, "_out_valid_timeout"}, 32'(ov), 32'd1);
      ordy = 1'b0;
      return;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    c = cobs;
    check({tag, "_c_x"}, 32'(c[0]), 32'(exp_c[0]));
    check({tag, "_c_y"}, 32'(c[1]), 32'(exp_c[1]));
    check({tag, "_c_z"}, 32'(c[2]), 32'(exp_c[2]));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (cobs !== c || !ov || ir) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_backpressure_hold"}, 32'(stable), 32'd1);
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(ov), 32'd0);
    check({tag, "_in_ready_after"}, 32'(ir), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0][15:0] basis_a, basis_b, gen_a, gen_b, c;
    basis_a = {16'h0000, 16'h0000, 16'h3C00};
    basis_b = {16'h0000, 16'h3C00, 16'h0000};
    gen_a   = {16'h4200, 16'h4000, 16'h3C00};
    gen_b   = {16'h4600, 16'h4500, 16'h4400};
    rst = 1'b0; iv = 1'b0; ordy = 1'b0; sel = 0; opa = '0; opb = '0;
`ifdef FP_CROSS_VEC2_EN
    md = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(ir), 32'd1);
    check("reset_out_valid", 32'(ov), 32'd0);
    check("reset_c", 32'({cobs[2][7:0], cobs[1][7:0], cobs[0][7:0]} | {8'd0, cobs[2][15:8], cobs[1][15:8], cobs[0][15:8]}), 32'd0);
    rst = 1'b1;

    do_op("basis", basis_a, basis_b, 1'b0, 0, 1'b0, 12, c);
    check("basis_cx_zero", 32'(c[0][14:0]), 32'd0);
    check("basis_cy_zero", 32'(c[1][14:0]), 32'd0);
    check("basis_cz_one", 32'(c[2]), 32'h3C00);

    do_op("general_bp", gen_a, gen_b, 1'b0, 20, 1'b0, 12, c);
    check("general_const", 32'({c[2], c[1]}), 32'hC2004600);
    check("general_const_cx", 32'(c[0]), 32'hC200);

    do_op("disturb", gen_a, gen_b, 1'b0, 0, 1'b1, 12, c);

    for (int i = 0; i < 24; i++) do_op("rand3d", rand_v(), rand_v(), 1'b0, i % 3, 1'b0, 12, c);

    sel = 1;
    do_op("lat32_disturb", gen_a, gen_b, 1'b0, 0, 1'b1, 15, c);
    check("lat32_const_cz", 32'(c[2]), 32'hC200);
    for (int i = 0; i < 6; i++) do_op("lat32_rand", rand_v(), rand_v(), 1'b0, 2, 1'b0, 15, c);

    sel = 0;
    @(negedge clk);
    opa = gen_a; opb = gen_b; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_in_ready", 32'(ir), 32'd1);
    check("midreset_out_valid", 32'(ov), 32'd0);
    check("midreset_c_x", 32'(cobs[0]), 32'd0);
    check("midreset_c_y", 32'(cobs[1]), 32'd0);
    check("midreset_c_z", 32'(cobs[2]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op("after_reset", basis_a, basis_b, 1'b0, 0, 1'b0, 12, c);
    do_op("after_reset_gen", gen_a, gen_b, 1'b0, 0, 1'b0, 12, c);

`ifdef FP_CROSS_VEC2_EN
    do_op("vec2", {16'h7BFF, 16'h4000, 16'h3C00}, {16'h7BFF, 16'h4500, 16'h4400}, 1'b1, 0, 1'b0, 6, c);
    check("vec2_const_cz", 32'(c[2]), 32'hC200);
    for (int i = 0; i < 8; i++) do_op("vec2_rand", rand_v(), rand_v(), 1'b1, 1, 1'b0, 6, c);
    do_op("vec2_then_3d", gen_a, gen_b, 1'b0, 0, 1'b0, 12, c);
    sel = 1;
    do_op("vec2_lat32", rand_v(), rand_v(), 1'b1, 0, 1'b1, 9, c);
    sel = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
